// File: rtl/vnu_upd_pkg.sv
// Shared definitions for the variable-node update stage: width derivations,
// lane slicing and the symmetric signed saturation used by both datapath stages.
package vnu_upd_pkg;

  // Wide signed scratch type; every intermediate sum fits well inside 32 bits.
  typedef logic signed [31:0] wide_t;

  // q carries ext_w guard bits above the check-message width.
  function automatic int data_width(input int res_w, input int ext_w);
    return res_w + ext_w;
  endfunction

  // Layer counter width; a single-layer schedule still needs one bit.
  function automatic int lyr_width(input int n_lyr);
    return (n_lyr > 1) ? $clog2(n_lyr) : 1;
  endfunction

  // Bit offset of a lane inside a flattened D-lane bus.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  // Symmetric saturation to +/-(2^(w-1)-1); the most-negative code never appears.
  function automatic wide_t sat_w(input wide_t x, input int w);
    wide_t lim;
    lim = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/vnu_upd_if.sv
// Bundle of the row input, CNU side-channel and updated-LLR output of vnu_upd.
interface vnu_upd_if import vnu_upd_pkg::*; #(
  parameter int D     = 6,
  parameter int res_w = 6,
  parameter int ext_w = 3,
  parameter int app_w = 10,
  parameter int N_LYR = 4
) ();

  localparam int data_w = data_width(res_w, ext_w);
  localparam int lyr_w  = lyr_width(N_LYR);

  logic                 en;
  logic                 in_vld;
  logic [app_w*D-1:0]   L;
  logic [res_w*D-1:0]   r_old;
  logic [data_w*D-1:0]  q;
  logic                 q_vld;
  logic [res_w*D-1:0]   r_new;
  logic [app_w*D-1:0]   L_new;
  logic [D-1:0]         hd;
  logic                 out_vld;
  logic [lyr_w-1:0]     lyr_idx;
  logic                 iter_done;

  // Driver of the rows and of the CNU results (scheduler / bench side).
  modport master (
    output en, in_vld, L, r_old, r_new,
    input  q, q_vld, L_new, hd, out_vld, lyr_idx, iter_done
  );

  // The update stage itself.
  modport slave (
    input  en, in_vld, L, r_old, r_new,
    output q, q_vld, L_new, hd, out_vld, lyr_idx, iter_done
  );

endinterface

// File: rtl/vnu_upd_dly.sv
// LAT-deep enable-gated shift register carrying {valid, q row} alongside the CNU.
module vnu_dly #(
  parameter int LAT = 2,
  parameter int W   = 54
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         tail_vld,
  output logic [W-1:0] tail_data
);

  logic [LAT-1:0] vld_d, vld_q;
  logic [W-1:0]   data_d [LAT];
  logic [W-1:0]   data_q [LAT];

  // Shift one slot per enabled cycle; a disabled cycle freezes the whole line.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (en) begin
      vld_d[0]  = in_vld;
      data_d[0] = in_data;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end

  // Line storage; reset empties every slot so in-flight rows are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      data_q <= '{default: '0};
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign tail_vld  = vld_q[LAT-1];
  assign tail_data = data_q[LAT-1];

endmodule

// File: rtl/vnu_upd.sv
// Layered-decoding variable-node update: forms q = L - r_old for the CNU, keeps q
// aligned with the CNU latency and returns L_new = q + r_new with hard decisions.
module vnu_upd import vnu_upd_pkg::*; #(
  parameter int D     = 6,
  parameter int res_w = 6,
  parameter int ext_w = 3,
  parameter int app_w = 10,
  parameter int LAT   = 2,
  parameter int N_LYR = 4
) (
  input  logic     clk,
  input  logic     rst,
  vnu_upd_if.slave bus
);

  localparam int data_w = data_width(res_w, ext_w);
  localparam int lyr_w  = lyr_width(N_LYR);
  localparam logic [lyr_w-1:0] LYR_LAST = lyr_w'(N_LYR - 1);

  logic [data_w*D-1:0] q_new;
  logic [data_w*D-1:0] q_d, q_q;
  logic                q_vld_d, q_vld_q;
  logic                tail_vld;
  logic [data_w*D-1:0] tail_data;
  logic [app_w*D-1:0]  l_new_next;
  logic [app_w*D-1:0]  l_new_d, l_new_q;
  logic                out_vld_d, out_vld_q;
  logic [lyr_w-1:0]    lyr_d, lyr_q;
  logic [D-1:0]        hd_w;

  // Per-lane arithmetic, done wide and then saturated back to the lane width.
  for (genvar i = 0; i < D; i++) begin : g_lane
    assign q_new[lane_lsb(i, data_w) +: data_w] = data_w'(sat_w(
        wide_t'(signed'(bus.L[lane_lsb(i, app_w) +: app_w])) -
        wide_t'(signed'(bus.r_old[lane_lsb(i, res_w) +: res_w])), data_w));

    assign l_new_next[lane_lsb(i, app_w) +: app_w] = app_w'(sat_w(
        wide_t'(signed'(tail_data[lane_lsb(i, data_w) +: data_w])) +
        wide_t'(signed'(bus.r_new[lane_lsb(i, res_w) +: res_w])), app_w));
  end

  // q rides next to the CNU so it meets r_new exactly when the CNU answers.
  vnu_dly #(
    .LAT (LAT),
    .W   (data_w * D)
  ) u_dly (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .in_vld    (q_vld_q),
    .in_data   (q_q),
    .tail_vld  (tail_vld),
    .tail_data (tail_data)
  );

  // Stage 1: capture q on a valid row; q holds its last value between rows.
  always_comb begin
    q_d     = q_q;
    q_vld_d = q_vld_q;
    if (bus.en) begin
      q_vld_d = bus.in_vld;
      if (bus.in_vld) q_d = q_new;
    end
  end

  // Stage 2: r_new only matters when the delay-line tail holds a real row.
  always_comb begin
    l_new_d   = l_new_q;
    out_vld_d = out_vld_q;
    if (bus.en) begin
      out_vld_d = tail_vld;
      if (tail_vld) l_new_d = l_new_next;
    end
  end

  // Layer counter advances once the current output row has been presented.
  always_comb begin
    lyr_d = lyr_q;
    if (bus.en && out_vld_q) begin
      lyr_d = (lyr_q == LYR_LAST) ? '0 : lyr_q + lyr_w'(1);
    end
  end

  // Hard decision is the sign bit of each updated lane.
  always_comb begin
    hd_w = '0;
    for (int i = 0; i < D; i++) begin
      hd_w[i] = l_new_q[lane_lsb(i, app_w) + app_w - 1];
    end
  end

  // Pipeline state; reset clears everything at once, mid-row included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q       <= '0;
      q_vld_q   <= 1'b0;
      l_new_q   <= '0;
      out_vld_q <= 1'b0;
      lyr_q     <= '0;
    end else begin
      q_q       <= q_d;
      q_vld_q   <= q_vld_d;
      l_new_q   <= l_new_d;
      out_vld_q <= out_vld_d;
      lyr_q     <= lyr_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.q_vld     = q_vld_q;
  assign bus.L_new     = l_new_q;
  assign bus.hd        = hd_w;
  assign bus.out_vld   = out_vld_q;
  assign bus.lyr_idx   = lyr_q;
  assign bus.iter_done = out_vld_q && (lyr_q == LYR_LAST);

endmodule

// File: tb/tb_vnu_upd.sv
// Bench for vnu_upd: fixed vectors, multi-cycle corner sequences and random rows
// checked against a row-level model that tracks enabled cycles, not RTL state.
module tb_vnu_upd;

  localparam int D      = 6;
  localparam int res_w  = 6;
  localparam int ext_w  = 3;
  localparam int app_w  = 10;
  localparam int app9   = 9;
  localparam int LAT    = 2;
  localparam int N_LYR  = 4;
  localparam int data_w = res_w + ext_w;
  localparam int LW     = D * app_w;
  localparam int LW9    = D * app9;
  localparam int RW     = D * res_w;

  typedef struct {
    bit use9;
    int l;
    int ro;
    int rn;
    int exp_q;
    int exp_ln;
    bit exp_hd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  int n_cmp = 0;
  int n_bad = 0;

  int ecnt = 0;
  int last_ecnt = 0;
  int lyr_issue = 0;
  int iter_seen = 0;
  int out_rows = 0;

  logic [63:0] q_at [int];
  logic [63:0] rnew_at [int];
  logic [63:0] lnew_at [int];
  logic [63:0] hd_at [int];
  int          lyr_at [int];

  vnu_upd_if #(.D(D), .res_w(res_w), .ext_w(ext_w), .app_w(app_w), .N_LYR(N_LYR)) bus ();
  vnu_upd_if #(.D(D), .res_w(res_w), .ext_w(ext_w), .app_w(app9), .N_LYR(N_LYR)) bus9 ();

  assign bus.en  = en;
  assign bus9.en = en;

  vnu_upd #(
    .D(D), .res_w(res_w), .ext_w(ext_w), .app_w(app_w), .LAT(LAT), .N_LYR(N_LYR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vnu_upd #(
    .D(D), .res_w(res_w), .ext_w(ext_w), .app_w(app9), .LAT(LAT), .N_LYR(N_LYR)
  ) dut9 (
    .clk (clk),
    .rst (rst),
    .bus (bus9.slave)
  );

  always #5 clk = ~clk;

  // Count of enabled edges: the time base the model schedules every row on.
  always @(posedge clk) if (en) ecnt <= ecnt + 1;

  function automatic int clampw(input int x, input int w);
    int m;
    m = (1 << (w - 1)) - 1;
    if (x > m) return m;
    if (x < -m) return -m;
    return x;
  endfunction

  function automatic logic [63:0] pack(input int v[D], input int w);
    logic [63:0] r;
    logic [63:0] m;
    r = '0;
    m = (64'd1 << w) - 64'd1;
    for (int i = 0; i < D; i++) r = r | ((64'(v[i]) & m) << (i * w));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Issue one row on the main DUT (caller guarantees en=1 this cycle) and schedule its results.
  task automatic issue_row(input int lv[D], input int rv[D], input int nv[D]);
    int qv[D];
    int ov[D];
    int hv[D];
    int t;
    for (int i = 0; i < D; i++) begin
      qv[i] = clampw(lv[i] - rv[i], data_w);
      ov[i] = clampw(qv[i] + nv[i], app_w);
      hv[i] = (ov[i] < 0) ? 1 : 0;
    end
    bus.in_vld = 1'b1;
    bus.L      = LW'(pack(lv, app_w));
    bus.r_old  = RW'(pack(rv, res_w));
    t = ecnt + 1;
    q_at[t]            = pack(qv, data_w);
    rnew_at[t + LAT]   = pack(nv, res_w);
    lnew_at[t + LAT + 1] = pack(ov, app_w);
    hd_at[t + LAT + 1]   = pack(hv, 1);
    lyr_at[t + LAT + 1]  = lyr_issue % N_LYR;
    lyr_issue++;
  endtask

  task automatic random_row(input int lbase, input bit fixed_l);
    int lv[D];
    int rv[D];
    int nv[D];
    for (int i = 0; i < D; i++) begin
      lv[i] = fixed_l ? lbase : int'($urandom_range(1023)) - 512;
      rv[i] = int'($urandom_range(63)) - 32;
      nv[i] = int'($urandom_range(63)) - 32;
    end
    issue_row(lv, rv, nv);
  endtask

  task automatic clear_model();
    q_at.delete();
    rnew_at.delete();
    lnew_at.delete();
    hd_at.delete();
    lyr_at.delete();
    lyr_issue = 0;
  endtask

  // One fixed vector: issue, then check q at +1, no output at +3, result at +4.
  task automatic applyStimulus(input vec_t v, input int idx);
    int lv[D];
    int rv[D];
    int nv[D];
    int ev[D];
    int ln[D];
    logic [63:0] exp_q;
    logic [63:0] exp_ln;
    logic [63:0] exp_hd;
    for (int i = 0; i < D; i++) begin
      lv[i] = v.l;
      rv[i] = v.ro;
      nv[i] = v.rn;
      ev[i] = v.exp_q;
      ln[i] = v.exp_ln;
    end
    exp_q  = pack(ev, data_w);
    exp_ln = pack(ln, v.use9 ? app9 : app_w);
    exp_hd = v.exp_hd ? 64'h3f : 64'h0;
    @(negedge clk);
    if (v.use9) begin
      bus9.in_vld = 1'b1;
      bus9.L      = LW9'(pack(lv, app9));
      bus9.r_old  = RW'(pack(rv, res_w));
      bus9.r_new  = RW'(pack(nv, res_w));
    end else begin
      issue_row(lv, rv, nv);
    end
    @(negedge clk);
    bus.in_vld  = 1'b0;
    bus9.in_vld = 1'b0;
    if (v.use9) begin
      checkOutput($sformatf("vec%0d q_vld", idx), 64'(bus9.q_vld), 64'd1);
      checkOutput($sformatf("vec%0d q", idx), 64'(bus9.q), exp_q);
    end else begin
      checkOutput($sformatf("vec%0d q_vld", idx), 64'(bus.q_vld), 64'd1);
      checkOutput($sformatf("vec%0d q", idx), 64'(bus.q), exp_q);
    end
    repeat (2) @(negedge clk);
    checkOutput($sformatf("vec%0d early out_vld", idx),
                64'(v.use9 ? bus9.out_vld : bus.out_vld), 64'd0);
    @(negedge clk);
    if (v.use9) begin
      checkOutput($sformatf("vec%0d out_vld", idx), 64'(bus9.out_vld), 64'd1);
      checkOutput($sformatf("vec%0d L_new", idx), 64'(bus9.L_new), exp_ln);
      checkOutput($sformatf("vec%0d hd", idx), 64'(bus9.hd), exp_hd);
    end else begin
      checkOutput($sformatf("vec%0d out_vld", idx), 64'(bus.out_vld), 64'd1);
      checkOutput($sformatf("vec%0d L_new", idx), 64'(bus.L_new), exp_ln);
      checkOutput($sformatf("vec%0d hd", idx), 64'(bus.hd), exp_hd);
    end
  endtask

  // Model-driven monitor and CNU stand-in for the main DUT, sampled 2 units after each edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        checkOutput("rst q_vld", 64'(bus.q_vld), 64'd0);
        checkOutput("rst q", 64'(bus.q), 64'd0);
        checkOutput("rst out_vld", 64'(bus.out_vld), 64'd0);
        checkOutput("rst L_new", 64'(bus.L_new), 64'd0);
        checkOutput("rst lyr_idx", 64'(bus.lyr_idx), 64'd0);
        checkOutput("rst iter_done", 64'(bus.iter_done), 64'd0);
      end else begin
        checkOutput("q_vld", 64'(bus.q_vld), 64'(q_at.exists(ecnt)));
        if (q_at.exists(ecnt)) checkOutput("q", 64'(bus.q), q_at[ecnt]);
        checkOutput("out_vld", 64'(bus.out_vld), 64'(lnew_at.exists(ecnt)));
        if (lnew_at.exists(ecnt)) begin
          checkOutput("L_new", 64'(bus.L_new), lnew_at[ecnt]);
          checkOutput("hd", 64'(bus.hd), hd_at[ecnt]);
          checkOutput("lyr_idx", 64'(bus.lyr_idx), 64'(lyr_at[ecnt]));
          checkOutput("iter_done", 64'(bus.iter_done), 64'(lyr_at[ecnt] == N_LYR - 1));
        end else begin
          checkOutput("iter_done idle", 64'(bus.iter_done), 64'd0);
        end
        if (bus.out_vld && bus.iter_done) iter_seen++;
        if (bus.out_vld && ecnt != last_ecnt) out_rows++;
      end
      last_ecnt = ecnt;
      if (rnew_at.exists(ecnt)) bus.r_new = RW'(rnew_at[ecnt]);
      else bus.r_new = RW'({$urandom, $urandom});
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    vec_t tbl[7];
    int   rows0;

    tbl[0] = '{use9: 1'b0, l: 100,  ro: -20, rn: 15,  exp_q: 120,  exp_ln: 135,  exp_hd: 1'b0};
    tbl[1] = '{use9: 1'b0, l: 500,  ro: -31, rn: 31,  exp_q: 255,  exp_ln: 286,  exp_hd: 1'b0};
    tbl[2] = '{use9: 1'b0, l: -511, ro: 31,  rn: -31, exp_q: -255, exp_ln: -286, exp_hd: 1'b1};
    tbl[3] = '{use9: 1'b1, l: 255,  ro: -31, rn: 31,  exp_q: 255,  exp_ln: 255,  exp_hd: 1'b0};
    tbl[4] = '{use9: 1'b1, l: -256, ro: 31,  rn: -31, exp_q: -255, exp_ln: -255, exp_hd: 1'b1};
    tbl[5] = '{use9: 1'b0, l: -512, ro: -32, rn: -32, exp_q: -255, exp_ln: -287, exp_hd: 1'b1};
    tbl[6] = '{use9: 1'b0, l: 0,    ro: 0,   rn: 0,   exp_q: 0,    exp_ln: 0,    exp_hd: 1'b0};

    rst = 1'b1;
    en  = 1'b0;
    bus.in_vld  = 1'b0;
    bus.L       = '0;
    bus.r_old   = '0;
    bus9.in_vld = 1'b0;
    bus9.L      = '0;
    bus9.r_old  = '0;
    bus9.r_new  = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset q9", 64'(bus9.q), 64'd0);
    checkOutput("reset out_vld9", 64'(bus9.out_vld), 64'd0);
    rst = 1'b1;
    en  = 1'b1;
    $display("[TB] reset released");

    // Layer sequence: 9 rows streamed from a fresh counter.
    iter_seen = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      random_row(0, 1'b0);
    end
    @(negedge clk);
    bus.in_vld = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    checkOutput("iter_done count", 64'(iter_seen), 64'd2);

    // Fixed vectors, including saturation boundaries and the 9-bit APP instance.
    for (int k = 0; k < 7; k++) applyStimulus(tbl[k], k);
    repeat (2) @(negedge clk);

    // Back-to-back rows with a 3-cycle enable drop after row 3; junk in_vld while frozen.
    rows0 = out_rows;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      en = 1'b1;
      random_row(8 + k, 1'b1);
      if (k == 3) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          en = 1'b0;
          bus.in_vld = 1'b1;
          bus.L      = LW'({$urandom, $urandom});
        end
      end
    end
    @(negedge clk);
    en = 1'b1;
    bus.in_vld = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    checkOutput("stream row count", 64'(out_rows - rows0), 64'd8);

    // Asynchronous reset with three rows in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      random_row(0, 1'b0);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.in_vld = 1'b0;
    clear_model();
    #1;
    checkOutput("async q_vld", 64'(bus.q_vld), 64'd0);
    checkOutput("async q", 64'(bus.q), 64'd0);
    checkOutput("async L_new", 64'(bus.L_new), 64'd0);
    checkOutput("async out_vld", 64'(bus.out_vld), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    random_row(0, 1'b0);
    @(negedge clk);
    bus.in_vld = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    checkOutput("post-reset out_vld", 64'(bus.out_vld), 64'd1);
    checkOutput("post-reset lyr_idx", 64'(bus.lyr_idx), 64'd0);
    repeat (2) @(negedge clk);

    // Random rows, random enable and junk in_vld during frozen cycles.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      en = ($urandom_range(7) != 0);
      if (en && $urandom_range(3) != 0) begin
        random_row(0, 1'b0);
      end else begin
        bus.in_vld = en ? 1'b0 : 1'($urandom_range(1));
        bus.L      = LW'({$urandom, $urandom});
        bus.r_old  = RW'({$urandom, $urandom});
      end
    end
    @(negedge clk);
    en = 1'b1;
    bus.in_vld = 1'b0;
    repeat (LAT + 6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vnu_upd.md
Name: vnu_upd

Overview:
- Layered-decoding variable-node update stage. It wraps the check-node unit: it forms the variable-to-check messages q = L - r_old for one row of D edges and drives them to the CNU.
- It holds each q in a delay line for the CNU latency, then consumes the CNU result r_new and produces the updated APP LLRs L_new = q + r_new plus hard decisions.
- A layer/iteration counter marks the end of each decoding iteration.

Parameters:
D, 6, edges per check row (must match the CNU)
res_w, 6, check-message width (two's complement, r_old/r_new)
ext_w, 3, extra bits of q over res_w; data_w = res_w + ext_w (local)
app_w, 10, APP LLR width (L, L_new), app_w > data_w
LAT, 2, cycles from q_vld to r_new valid at the CNU output (>=1)
N_LYR, 4, layers per iteration (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global enable; also drives the CNU en; low = whole stage frozen
in_vld  in  1  L/r_old row valid this cycle
L  in  app_w*D  current APP LLRs, lane i at [i*app_w +: app_w]
r_old  in  res_w*D  previous check messages for this row
q  out  data_w*D  messages to CNU, registered
q_vld  out  1  q valid
r_new  in  res_w*D  CNU output, sampled exactly LAT enabled cycles after q_vld
L_new  out  app_w*D  updated APP LLRs, registered
hd  out  D  hard decision, hd[i] = sign bit of L_new lane i
out_vld  out  1  L_new/hd valid
lyr_idx  out  clog2(N_LYR)  layer index of the current out_vld row
iter_done  out  1  pulses with the out_vld of layer N_LYR-1

Behaviour:
- Reset (rst=0, async): q, L_new, hd, lyr_idx = 0. q_vld, out_vld, iter_done = 0. Delay-line contents and valid bits = 0. Takes effect immediately, including mid-row. Rows in flight are discarded and produce no out_vld.
- en=0: every register holds, including the delay line, valids and counter. Outputs stay stable. in_vld is ignored.
- All arithmetic is signed two's complement. Saturation is symmetric to +/-(2^(w-1)-1); the most-negative code is never produced.
- Stage 1, the first enabled edge with in_vld=1:
  - q_i = sat_data_w(sext(L_i) - sext(r_old_i)), computed at app_w+1 bits.
  - q_vld = 1 the next cycle; otherwise q_vld = 0 and q holds its last value.
- Delay line: a shift register of LAT entries (q word + valid) advanced on every enabled edge. Its tail aligns with the cycle in which r_new is sampled.
- Stage 2, enabled edge where the delay-line tail is valid:
  - L_new_i = sat_app_w(sext(q_tail_i) + sext(r_new_i)).
  - hd = sign bits of L_new; out_vld = 1 the next cycle.
- Latency: out_vld rises exactly LAT+2 enabled cycles after the in_vld edge. Throughput is one row per cycle; back-to-back in_vld is fully supported and there is no back-pressure.
- Counter:
  - lyr_idx is the layer of the row currently on out_vld.
  - It increments after each out_vld cycle and wraps from N_LYR-1 to 0.
  - iter_done = out_vld AND (lyr_idx == N_LYR-1).
  - N_LYR=1: iter_done accompanies every out_vld.
- r_new is ignored in cycles where the tail is invalid (bubbles).

Decomposition:
- Shared package holds: data_w derivation, lane slice widths, and signed saturate functions sat_w(x, w) used by both stages and reusable by the CNU bench.
- One natural sub-module: vnu_dly, a parameterised LAT-deep, enable-gated shift register of {valid, data_w*D} with async active-low clear.

Test Plan:
- D=6 defaults, all lanes L=100, r_old=-20 -> q=120 with q_vld at +1. Bench CNU model returns r_new=15 at +LAT+1 -> L_new=135, hd=0, out_vld exactly at +4.
- L=500, r_old=-31 -> q=255 (saturated from 531). r_new=31 -> L_new=286. Lane L=-511, r_old=31 -> q=-255. r_new=-31 -> L_new=-286, hd=1.
- Saturation check with app_w reduced to 9 in the bench: q=255, r_new=31 -> L_new=255, never 286. Saturation on -256 is never seen.
- 8 back-to-back rows with distinct L values (8..15), en dropped for 3 cycles after row 3 -> outputs are in order, unchanged, and the row-4 onward delivery shifts by exactly 3 cycles. No duplicate or lost out_vld.
- N_LYR=4, 9 rows streamed -> lyr_idx sequence 0,1,2,3,0,1,2,3,0; iter_done high on rows 4 and 8 only.
- Assert rst low for one cycle while 3 rows are in flight -> all outputs 0 immediately and no out_vld for those rows. A new row issued after release emerges LAT+2 cycles later with lyr_idx=0.
